// File: rtl/mem_fill_responder.sv
// mem_fill_responder: pipelined word memory answering cache fill reads LATENCY cycles after issue.
// Define MEM_RD_ADDR_ECHO_EN to carry the word-aligned read address out on data_addr.
module mem_fill_responder #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] address,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [3:0]  pending
`ifdef MEM_RD_ADDR_ECHO_EN
    ,
    output logic [15:0] data_addr
`endif
);
    localparam int WORDS = 1 << DEPTH_LOG2;

    logic [15:0]           mem [WORDS];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  rd_issue;
    logic                  unused_addr;

    logic [LATENCY:1]       vld_pipe_q, vld_pipe_d;
    logic [LATENCY:1][15:0] dat_pipe_q, dat_pipe_d;
    logic [3:0]             pending_q, pending_d;
`ifdef MEM_RD_ADDR_ECHO_EN
    logic [LATENCY:1][15:0] adr_pipe_q, adr_pipe_d;
`endif

    assign idx         = address[DEPTH_LOG2:1];
    assign rd_issue    = enable & ~wr;
    assign unused_addr = ^address;

    // Storage is never reset; writes are simply suppressed while rst is low.
    always_ff @(posedge clk) begin
        if (rst && enable && wr) begin
            mem[idx] <= data_in;
        end
    end

    // Idle stages carry zero data so the last stage drives data_out directly.
    always_comb begin
        vld_pipe_d    = vld_pipe_q;
        dat_pipe_d    = dat_pipe_q;
        vld_pipe_d[1] = rd_issue;
        dat_pipe_d[1] = rd_issue ? mem[idx] : 16'h0;
        for (int i = 2; i <= LATENCY; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            dat_pipe_d[i] = dat_pipe_q[i-1];
        end
        pending_d = pending_q + 4'(rd_issue) - 4'(vld_pipe_q[LATENCY]);
    end

`ifdef MEM_RD_ADDR_ECHO_EN
    always_comb begin
        adr_pipe_d    = adr_pipe_q;
        adr_pipe_d[1] = rd_issue ? {address[15:1], 1'b0} : 16'h0;
        for (int i = 2; i <= LATENCY; i++) begin
            adr_pipe_d[i] = adr_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adr_pipe_q <= '0;
        end else begin
            adr_pipe_q <= adr_pipe_d;
        end
    end

    assign data_addr = adr_pipe_q[LATENCY];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe_q <= '0;
            dat_pipe_q <= '0;
            pending_q  <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            dat_pipe_q <= dat_pipe_d;
            pending_q  <= pending_d;
        end
    end

    assign data_valid = vld_pipe_q[LATENCY];
    assign data_out   = dat_pipe_q[LATENCY];
    assign pending    = pending_q;

endmodule

// File: tb/tb_mem_fill_responder.sv
// Self-checking bench for mem_fill_responder: directed scenarios plus random traffic vs a queue model.
// Build with MEM_RD_ADDR_ECHO_EN defined to also check data_addr ordering.
module tb_mem_fill_responder;
    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] address = 16'hFFFF;
    logic [15:0] data_in = 16'h0;
    logic [15:0] data_out;
    logic        data_valid;
    logic [3:0]  pending;
`ifdef MEM_RD_ADDR_ECHO_EN
    logic [15:0] data_addr;
`endif

    mem_fill_responder #(.LATENCY(L), .DEPTH_LOG2(15)) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .address(address),
        .data_in(data_in), .data_out(data_out), .data_valid(data_valid), .pending(pending)
`ifdef MEM_RD_ADDR_ECHO_EN
        , .data_addr(data_addr)
`endif
    );

    always #5 clk = ~clk;

    // Model: each read becomes a queue entry due L cycles after its issue cycle.
    typedef struct {
        int          due;
        logic [15:0] d;
        logic [15:0] a;
        bit          k;
    } ret_t;

    ret_t        q[$];
    logic [15:0] mm    [0:32767];
    bit          known [0:32767];
    int          cyc, n_chk, n_fail;
    logic        exp_dv;
    logic [15:0] exp_do, exp_ad;
    bit          exp_k;
    int          exp_pend;

    task automatic model_expect();
        exp_pend = q.size();
        exp_dv = 1'b0; exp_do = 16'h0; exp_ad = 16'h0; exp_k = 1'b1;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_dv = 1'b1; exp_do = q[0].d; exp_ad = q[0].a; exp_k = q[0].k;
        end
    endtask

    task automatic cycle(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        ret_t r;
        enable = en; wr = w; address = a; data_in = d;
        @(posedge clk);
        if (exp_dv) void'(q.pop_front());
        if (en && !w) begin
            r.due = cyc + L; r.d = mm[a[15:1]]; r.a = {a[15:1], 1'b0}; r.k = known[a[15:1]];
            q.push_back(r);
        end
        if (en && w) begin
            mm[a[15:1]] = d; known[a[15:1]] = 1'b1;
        end
        cyc++;
        #1;
        model_expect();
    endtask

    task automatic test_reset();
        #2;
        n_chk++;
        if (data_valid !== 1'b0 || data_out !== 16'h0 || pending !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_state: dv=%b data=%h pend=%0d, expected 0/0000/0", data_valid, data_out, pending);
        end
`ifdef MEM_RD_ADDR_ECHO_EN
        n_chk++;
        if (data_addr !== 16'h0) begin
            n_fail++; $display("FAIL reset_addr: data_addr=%h, expected 0000", data_addr);
        end
`endif
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        cyc = 0; q.delete(); model_expect();
    endtask

    task automatic test_single();
        int n;
        cycle(1'b1, 1'b1, 16'h0010, 16'hA5A5);
        n = cyc;
        cycle(1'b1, 1'b0, 16'h0010, 16'h0);
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (data_valid !== 1'(cyc == n + L) || data_out !== ((cyc == n + L) ? 16'hA5A5 : 16'h0)
                || pending !== exp_pend[3:0]) begin
                n_fail++;
                $display("FAIL single_rw: cyc+%0d dv=%b data=%h pend=%0d, expected dv=%b data=%h pend=%0d",
                         cyc - n, data_valid, data_out, pending, (cyc == n + L),
                         (cyc == n + L) ? 16'hA5A5 : 16'h0, exp_pend);
            end
            cycle(1'b0, 1'b0, 16'hFFFF, 16'h0);
        end
    endtask

    task automatic test_fill_burst();
        logic [15:0] seen[$];
        int first, last, maxp;
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 16'h0100 + 16'(2*i), 16'h1000 + 16'(i));
        first = -1; last = -1; maxp = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(i < 8, 1'b0, 16'h0100 + 16'(2*(i % 8)), 16'h0);
            n_chk++;
            if (data_valid !== exp_dv || pending !== exp_pend[3:0] || (exp_k && data_out !== exp_do)) begin
                n_fail++;
                $display("FAIL fill_burst: cyc=%0d dv=%b pend=%0d data=%h, expected dv=%b pend=%0d data=%h",
                         cyc, data_valid, pending, data_out, exp_dv, exp_pend, exp_do);
            end
            if (data_valid) begin
`ifdef MEM_RD_ADDR_ECHO_EN
                n_chk++;
                if (data_addr !== 16'h0100 + 16'(2*seen.size())) begin
                    n_fail++;
                    $display("FAIL fill_addr: data_addr=%h, expected %h", data_addr, 16'h0100 + 16'(2*seen.size()));
                end
`endif
                seen.push_back(data_out);
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (int'(pending) > maxp) maxp = int'(pending);
        end
        n_chk++;
        if (seen.size() != 8 || last - first != 7 || maxp != L || pending !== 4'h0) begin
            n_fail++;
            $display("FAIL fill_shape: words=%0d span=%0d maxpend=%0d endpend=%0d, expected 8/7/%0d/0",
                     seen.size(), last - first, maxp, pending, L);
        end
        for (int i = 0; i < seen.size(); i++) begin
            n_chk++;
            if (seen[i] !== 16'h1000 + 16'(i)) begin
                n_fail++; $display("FAIL fill_order: word %0d=%h, expected %h", i, seen[i], 16'h1000 + 16'(i));
            end
        end
    endtask

    task automatic test_raw();
        logic [15:0] seen[$];
        int n, dvc[$];
        cycle(1'b1, 1'b1, 16'h0020, 16'h1111);
        cycle(1'b1, 1'b0, 16'h0020, 16'h0);
        n = cyc;
        cycle(1'b1, 1'b1, 16'h0020, 16'hBEEF);
        cycle(1'b1, 1'b0, 16'h0020, 16'h0);
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (data_valid !== exp_dv || pending !== exp_pend[3:0] || (exp_k && data_out !== exp_do)) begin
                n_fail++;
                $display("FAIL raw_model: cyc=%0d dv=%b pend=%0d data=%h, expected dv=%b pend=%0d data=%h",
                         cyc, data_valid, pending, data_out, exp_dv, exp_pend, exp_do);
            end
            if (data_valid) begin seen.push_back(data_out); dvc.push_back(cyc - n); end
            cycle(1'b0, 1'b0, 16'hFFFF, 16'h0);
        end
        n_chk++;
        if (seen.size() != 2 || seen[0] !== 16'h1111 || seen[1] !== 16'hBEEF || dvc[0] != L - 1 || dvc[1] != L + 1) begin
            n_fail++;
            $display("FAIL raw_hazard: got %0d words, expected 1111 at N+%0d and BEEF at N+%0d", seen.size(), L - 1, L + 1);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] seen[$];
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0100 + 16'(2*i), 16'h0);
        enable = 1'b1; wr = 1'b1; address = 16'h0100; data_in = 16'hDEAD;
        #1 rst = 1'b0;
        #1;
        n_chk++;
        if (data_valid !== 1'b0 || data_out !== 16'h0 || pending !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_async: dv=%b data=%h pend=%0d, expected 0/0000/0", data_valid, data_out, pending);
        end
        @(posedge clk); #3;
        enable = 1'b0; wr = 1'b0; address = 16'hFFFF; rst = 1'b1;
        @(posedge clk); #1;
        q.delete(); model_expect();
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if (data_valid !== 1'b0 || data_out !== 16'h0 || pending !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_stale: cyc=%0d dv=%b data=%h pend=%0d, expected 0/0000/0", cyc, data_valid, data_out, pending);
            end
            cycle(1'b0, 1'b0, 16'hFFFF, 16'h0);
        end
        for (int i = 0; i < 3 + L + 1; i++) begin
            cycle(i < 3, 1'b0, 16'h0100 + 16'(2*i), 16'h0);
            if (data_valid) seen.push_back(data_out);
        end
        n_chk++;
        if (seen.size() != 3 || seen[0] !== 16'h1000 || seen[1] !== 16'h1001 || seen[2] !== 16'h1002) begin
            n_fail++;
            $display("FAIL reset_contents: got %0d words first=%h, expected 1000 1001 1002",
                     seen.size(), (seen.size() > 0) ? seen[0] : 16'h0);
        end
    endtask

    task automatic test_alias_idle();
        logic [15:0] seen[$];
        int idle_dv;
        cycle(1'b1, 1'b1, 16'h0011, 16'h1234);
        cycle(1'b1, 1'b1, 16'hFFFE, 16'h5A5A);
        cycle(1'b1, 1'b0, 16'h0010, 16'h0);
        for (int i = 0; i < L; i++) begin
            if (data_valid) seen.push_back(data_out);
            cycle(1'b0, 1'b0, 16'hFFFF, 16'h0);
        end
        if (data_valid) seen.push_back(data_out);
        idle_dv = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 16'hFFFF, 16'($urandom));
            if (data_valid) idle_dv++;
        end
        n_chk++;
        if (seen.size() != 1 || seen[0] !== 16'h1234 || idle_dv != 0) begin
            n_fail++;
            $display("FAIL alias_idle: words=%0d first=%h idle_dv=%0d, expected 1/1234/0",
                     seen.size(), (seen.size() > 0) ? seen[0] : 16'h0, idle_dv);
        end
        seen.delete();
        cycle(1'b1, 1'b0, 16'hFFFF, 16'h0);
        for (int i = 0; i < L + 1; i++) begin
            if (data_valid) seen.push_back(data_out);
            cycle(1'b0, 1'b0, 16'hFFFF, 16'h0);
        end
        n_chk++;
        if (seen.size() != 1 || seen[0] !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL idle_nochange: words=%0d first=%h, expected 1/5A5A",
                     seen.size(), (seen.size() > 0) ? seen[0] : 16'h0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 64; i++) cycle(1'b1, 1'b1, 16'(2*i), 16'($urandom));
        for (int i = 0; i < 300 + L + 1; i++) begin
            if (i < 300) cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 127)), 16'($urandom));
            else cycle(1'b0, 1'b0, 16'hFFFF, 16'h0);
            n_chk++;
            if (data_valid !== exp_dv || pending !== exp_pend[3:0] || (exp_k && data_out !== exp_do)) begin
                n_fail++;
                $display("FAIL random: cyc=%0d dv=%b pend=%0d data=%h, expected dv=%b pend=%0d data=%h",
                         cyc, data_valid, pending, data_out, exp_dv, exp_pend, exp_do);
            end
`ifdef MEM_RD_ADDR_ECHO_EN
            n_chk++;
            if (data_addr !== exp_ad) begin
                n_fail++; $display("FAIL random_addr: cyc=%0d data_addr=%h, expected %h", cyc, data_addr, exp_ad);
            end
`endif
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        for (int i = 0; i < 32768; i++) begin mm[i] = 16'h0; known[i] = 1'b0; end
        model_expect();
        test_reset();
        test_single();
        test_fill_burst();
        test_raw();
        test_reset_mid_burst();
        test_alias_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
